// File: rtl/fpu_issue_ctrl_if.sv
// Port bundle for fpu_issue_ctrl: decoded-instruction request, div/sqrt handshake,
// FP write port, stall counters and the div/sqrt FSM state for debug.
interface fpu_issue_ctrl_if;
  // Every channel transfers on a cycle where valid and ready are both high.
  // A valid stays high and its payload stays stable until that cycle.
  // io_req_ready and io_ds_resp_ready never look at the matching valid.
  logic        io_req_valid;
  logic        io_req_ready;
  logic        io_sigs_wen;
  logic        io_sigs_ren1;
  logic        io_sigs_ren2;
  logic        io_sigs_ren3;
  logic        io_sigs_fma;
  logic        io_sigs_fastpipe;
  logic        io_sigs_fromint;
  logic        io_sigs_div;
  logic        io_sigs_sqrt;
  logic [4:0]  io_req_rd;
  logic [4:0]  io_req_rs1;
  logic [4:0]  io_req_rs2;
  logic [4:0]  io_req_rs3;
  logic        io_ds_req_valid;
  logic        io_ds_req_ready;
  logic        io_ds_req_sqrt;
  logic        io_ds_resp_valid;
  logic        io_ds_resp_ready;
  logic        io_wb_valid;
  logic [4:0]  io_wb_rd;
  logic        io_wb_sel;
  logic [31:0] io_perf_stall_raw;
  logic [31:0] io_perf_stall_struct;
  logic [1:0]  dbg_ds_state;  // 0 = IDLE, 1 = REQ, 2 = WAIT

  modport slave (
    input  io_req_valid, io_sigs_wen, io_sigs_ren1, io_sigs_ren2, io_sigs_ren3,
           io_sigs_fma, io_sigs_fastpipe, io_sigs_fromint, io_sigs_div, io_sigs_sqrt,
           io_req_rd, io_req_rs1, io_req_rs2, io_req_rs3,
           io_ds_req_ready, io_ds_resp_valid,
    output io_req_ready, io_ds_req_valid, io_ds_req_sqrt, io_ds_resp_ready,
           io_wb_valid, io_wb_rd, io_wb_sel,
           io_perf_stall_raw, io_perf_stall_struct, dbg_ds_state
  );

  modport master (
    output io_req_valid, io_sigs_wen, io_sigs_ren1, io_sigs_ren2, io_sigs_ren3,
           io_sigs_fma, io_sigs_fastpipe, io_sigs_fromint, io_sigs_div, io_sigs_sqrt,
           io_req_rd, io_req_rs1, io_req_rs2, io_req_rs3,
           io_ds_req_ready, io_ds_resp_valid,
    input  io_req_ready, io_ds_req_valid, io_ds_req_sqrt, io_ds_resp_ready,
           io_wb_valid, io_wb_rd, io_wb_sel,
           io_perf_stall_raw, io_perf_stall_struct, dbg_ds_state
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FP issue sequencer: register scoreboard, write-port reservation ring and div/sqrt FSM.
// Optional stall counters are built when FPU_ISSUE_PERF_EN is defined.
module fpu_issue_ctrl #(
  parameter int FMA_LATENCY  = 4,
  parameter int FAST_LATENCY = 2
) (
  input logic                clock,
  input logic                reset,
  fpu_issue_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_REQ  = 2'd1,
    DS_WAIT = 2'd2
  } ds_state_t;

  ds_state_t   ds_state;
  logic [4:0]  ds_rd;
  logic        ds_sqrt;
  logic [31:0] busy;

  // Slot i holds the write that reaches the register file i cycles from now.
  logic [FMA_LATENCY:1] ring_valid;
  logic [4:0]           ring_rd [FMA_LATENCY:1];

  logic        is_ds;
  logic        is_fma;
  logic        is_fast;
  logic        data_stall;
  logic        struct_stall;
  logic        ds_stall;
  logic        fire;
  logic        ds_resp_ready;
  logic        ds_wb;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] busy_set;
  logic [31:0] busy_clr;

  assign is_ds   = bus.io_sigs_div | bus.io_sigs_sqrt;
  assign is_fma  = ~is_ds & bus.io_sigs_wen & bus.io_sigs_fma;
  assign is_fast = ~is_ds & ~bus.io_sigs_fma & bus.io_sigs_wen
                 & (bus.io_sigs_fastpipe | bus.io_sigs_fromint);

  assign data_stall = (bus.io_sigs_ren1 & busy[bus.io_req_rs1])
                    | (bus.io_sigs_ren2 & busy[bus.io_req_rs2])
                    | (bus.io_sigs_ren3 & busy[bus.io_req_rs3])
                    | (bus.io_sigs_wen  & busy[bus.io_req_rd]);

  // After this cycle's shift, slot FAST_LATENCY holds what is now one slot higher.
  // FMA always lands in the freshly emptied top slot and never collides.
  assign struct_stall = is_fast & ring_valid[FAST_LATENCY+1];
  assign ds_stall     = is_ds & (ds_state != DS_IDLE);

  assign bus.io_req_ready = ~(data_stall | struct_stall | ds_stall);
  assign fire             = bus.io_req_valid & bus.io_req_ready;

  // The fixed-latency pipe owns the write port; div/sqrt waits behind ready.
  assign ds_resp_ready = (ds_state == DS_WAIT) & ~ring_valid[1];
  assign ds_wb         = ds_resp_ready & bus.io_ds_resp_valid;
  assign wb_valid      = ring_valid[1] | ds_wb;
  assign wb_rd         = ring_valid[1] ? ring_rd[1] : (ds_wb ? ds_rd : 5'd0);

  assign bus.io_ds_resp_ready = ds_resp_ready;
  assign bus.io_wb_valid      = wb_valid;
  assign bus.io_wb_rd         = wb_rd;
  assign bus.io_wb_sel        = ~ring_valid[1] & ds_wb;
  assign bus.io_ds_req_valid  = (ds_state == DS_REQ);
  assign bus.io_ds_req_sqrt   = ds_sqrt;
  assign bus.dbg_ds_state     = ds_state;

  assign busy_set = (fire & bus.io_sigs_wen & (is_fma | is_fast | is_ds))
                  ? (32'd1 << bus.io_req_rd) : 32'd0;
  assign busy_clr = wb_valid ? (32'd1 << wb_rd) : 32'd0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~busy_clr) | busy_set;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ring_valid <= '0;
      for (int i = 1; i <= FMA_LATENCY; i++) begin
        ring_rd[i] <= '0;
      end
    end else begin
      for (int i = 1; i < FMA_LATENCY; i++) begin
        ring_valid[i] <= ring_valid[i+1];
        ring_rd[i]    <= ring_rd[i+1];
      end
      ring_valid[FMA_LATENCY] <= 1'b0;
      if (fire && is_fma) begin
        ring_valid[FMA_LATENCY] <= 1'b1;
        ring_rd[FMA_LATENCY]    <= bus.io_req_rd;
      end
      if (fire && is_fast) begin
        ring_valid[FAST_LATENCY] <= 1'b1;
        ring_rd[FAST_LATENCY]    <= bus.io_req_rd;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ds_state <= DS_IDLE;
      ds_rd    <= '0;
      ds_sqrt  <= 1'b0;
    end else begin
      case (ds_state)
        DS_IDLE: begin
          if (fire && is_ds) begin
            ds_state <= DS_REQ;
            ds_rd    <= bus.io_req_rd;
            ds_sqrt  <= bus.io_sigs_sqrt;
          end
        end
        DS_REQ: begin
          if (bus.io_ds_req_ready) ds_state <= DS_WAIT;
        end
        DS_WAIT: begin
          if (ds_wb) ds_state <= DS_IDLE;
        end
        default: ds_state <= DS_IDLE;
      endcase
    end
  end

`ifdef FPU_ISSUE_PERF_EN
  logic [31:0] stall_raw;
  logic [31:0] stall_struct;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_raw    <= '0;
      stall_struct <= '0;
    end else if (bus.io_req_valid) begin
      if (data_stall) begin
        stall_raw <= stall_raw + 32'd1;
      end else if (struct_stall || ds_stall) begin
        stall_struct <= stall_struct + 32'd1;
      end
    end
  end

  assign bus.io_perf_stall_raw    = stall_raw;
  assign bus.io_perf_stall_struct = stall_struct;
`else
  assign bus.io_perf_stall_raw    = 32'd0;
  assign bus.io_perf_stall_struct = 32'd0;
`endif

endmodule
